// File: rtl/dem_pkg.sv
// dem_pkg: shared state encoding, channel indices and burst limits for dem_sched
package dem_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;
  localparam int BURST_MIN = 1;
  localparam int BURST_MAX = 16;
  localparam int CNT_W = 4;
  function automatic logic [3:0] ch_onehot(input logic [1:0] idx);
    return {idx == CH_D, idx == CH_C, idx == CH_B, idx == CH_A};
  endfunction
endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: combinational 4-way round-robin pick, first request at or above ptr (mod 4)
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_idx,
  output logic       any
);
  // scan downward so the lowest offset from ptr wins
  always_comb begin
    gnt_idx = ptr;
    for (int k = 3; k >= 0; k--) if (req[ptr + 2'(k)]) gnt_idx = ptr + 2'(k);
  end
  assign any = |req;
endmodule

// File: rtl/dem_sched.sv
// dem_sched: serial-to-4-channel burst demultiplexer with round-robin grants
module dem_sched
  import dem_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  input  logic [3:0] ch_en,
  input  logic [3:0] ch_ready,
  output logic       s0,
  output logic       s1,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] ch_valid,
  output logic       busy,
  output logic       burst_done
);
  localparam int BL = (BURST_LEN < BURST_MIN) ? BURST_MIN : (BURST_LEN > BURST_MAX) ? BURST_MAX : BURST_LEN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BL - 1);
  state_t           state_q;
  logic [1:0]       rr_ptr_q;
  logic [1:0]       g_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       dat_q;
  logic [3:0]       vld_q;
  logic             done_q;
  logic [1:0]       arb_idx;
  logic             arb_any;
  logic             acc;
  logic             last;
  rr_arb4 u_arb (
    .req    (ch_en & ch_ready),
    .ptr    (rr_ptr_q),
    .gnt_idx(arb_idx),
    .any    (arb_any)
  );
  assign in_ready = (state_q == SEND) && ch_en[g_q] && ch_ready[g_q];
  assign acc      = in_valid && in_ready;
  assign last     = acc && (cnt_q == LAST);
  // grant/burst FSM; channel outputs are registered one cycle after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= CH_A;
      g_q      <= CH_A;
      cnt_q    <= '0;
      dat_q    <= '0;
      vld_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      vld_q  <= acc ? ch_onehot(g_q) : '0;
      dat_q  <= (acc && in_data) ? ch_onehot(g_q) : '0;
      done_q <= last;
      if (state_q == IDLE) begin
        if (arb_any) begin
          state_q <= SEND;
          g_q     <= arb_idx;
          cnt_q   <= '0;
        end
      end else if (!ch_en[g_q] || last) begin
        state_q  <= IDLE;
        rr_ptr_q <= g_q + 2'd1;
      end else if (acc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
  assign busy       = (state_q == SEND);
  assign s0         = g_q[1];
  assign s1         = g_q[0];
  assign {d, c, b, a} = dat_q;
  assign ch_valid   = vld_q;
  assign burst_done = done_q;
endmodule
